// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, receiver states and token lookup
package tmds_pkg;

  localparam logic [9:0] TOKEN_00 = 10'h354;
  localparam logic [9:0] TOKEN_01 = 10'h0AB;
  localparam logic [9:0] TOKEN_10 = 10'h154;
  localparam logic [9:0] TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_t;

  // Returns {hit, ctrl}; ctrl is {c1,c0} and only meaningful when hit is set.
  function automatic logic [2:0] token_lookup(input logic [9:0] q);
    case (q)
      TOKEN_00: return 3'b100;
      TOKEN_01: return 3'b101;
      TOKEN_10: return 3'b110;
      TOKEN_11: return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - combinational 10b symbol to token/ctrl/pixel decode
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] q,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  // q[9] undoes the DC-balance inversion, q[8] selects XOR or XNOR chaining.
  always_comb begin
    {is_token, ctrl} = token_lookup(q);
    d = q[9] ? ~q[7:0] : q[7:0];
    data = 8'h00;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_receiver.sv
// rtl/tmds_channel_receiver.sv - TMDS channel word aligner, lock FSM and decoder
module tmds_channel_receiver
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS  = 4,
  parameter int MAX_DATA_RUN = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdata_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       word_valid,
  output logic       locked
);

  localparam int TW = $clog2(LOCK_TOKENS + 1);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [TW-1:0] TOK_MAX = TW'(LOCK_TOKENS);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

  rx_state_t     state;
  logic [9:0]    shreg;
  logic [3:0]    phase;
  logic [TW-1:0] tok_cnt;
  logic [RW-1:0] run_cnt;
  logic [TW-1:0] tok_inc;
  logic [RW-1:0] run_inc;
  logic          aligned;
  logic          is_token;
  logic [1:0]    dec_ctrl;
  logic [7:0]    dec_data;

  tmds_word_decode u_decode (
    .q        (shreg),
    .is_token (is_token),
    .ctrl     (dec_ctrl),
    .data     (dec_data)
  );

  // Saturating next values of the token and data-run counters.
  always_comb begin
    aligned = (phase == 4'd0);
    tok_inc = (tok_cnt == TOK_MAX) ? tok_cnt : tok_cnt + 1'b1;
    run_inc = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
  end

  // Shift register, symbol phase, lock FSM and registered word outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SEARCH;
      shreg      <= 10'd0;
      phase      <= 4'd0;
      tok_cnt    <= '0;
      run_cnt    <= '0;
      data_out   <= 8'h00;
      ctrl_out   <= 2'b00;
      de_out     <= 1'b0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      shreg      <= {sdata_in, shreg[9:1]};
      phase      <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
      word_valid <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (is_token) begin
            // The matching window counts as phase 0: next alignment is ten shifts on.
            phase   <= 4'd1;
            tok_cnt <= TW'(1);
            if (LOCK_TOKENS == 1) begin
              state   <= ST_LOCKED;
              locked  <= 1'b1;
              run_cnt <= '0;
            end else begin
              state <= ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (aligned) begin
            if (is_token) begin
              tok_cnt <= tok_inc;
              if (tok_inc == TOK_MAX) begin
                state   <= ST_LOCKED;
                locked  <= 1'b1;
                run_cnt <= '0;
              end
            end else begin
              state   <= ST_SEARCH;
              tok_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (aligned) begin
            word_valid <= 1'b1;
            if (is_token) begin
              de_out   <= 1'b0;
              ctrl_out <= dec_ctrl;
              run_cnt  <= '0;
            end else begin
              de_out   <= 1'b1;
              data_out <= dec_data;
              run_cnt  <= run_inc;
              // A long token-free run means we have probably slipped alignment.
              if (run_inc == RUN_MAX) begin
                state   <= ST_SEARCH;
                locked  <= 1'b0;
                tok_cnt <= '0;
              end
            end
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
